// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit time-multiplexing scanner feeding a 7-segment decoder.
// Steps a 3-bit digit select once every TICK_DIV clocks and muxes out the
// selected nibble plus a digit enable. New digits and blank masks arrive
// through a one-deep valid/ready buffer. The buffer is committed only at a
// frame boundary, so one frame never mixes old and new digits.
module seg_scan_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  blank_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        digit_en,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] prescaler;
  logic             tick;
  logic             boundary;
  logic             accept;
  logic             commit;

  logic [31:0]      active_data;
  logic [7:0]       active_blank;
  logic [31:0]      pend_data;
  logic [7:0]       pend_blank;
  logic             pending;

  assign tick     = (prescaler == TICK_LAST);
  assign boundary = tick && (sel == 3'd7);
  // Accept is only possible while the buffer is empty. This also rules out an
  // accept on the same edge as a commit.
  assign accept   = load_valid && !pending;
  assign commit   = boundary && pending;

  // Free-running slot prescaler; the handshake never stalls it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Digit select advances once per slot. frame_done marks the first slot of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        sel <= sel + 3'd1;
      end
    end
  end

  // One-deep pending buffer. It fills on accept and drains only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      pend_data  <= 32'd0;
      pend_blank <= 8'd0;
    end else if (commit) begin
      pending <= 1'b0;
    end else if (accept) begin
      pending    <= 1'b1;
      pend_data  <= data_in;
      pend_blank <= blank_in;
    end
  end

  // Active frame registers. The display stays dark (all blanked) until the first commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_data  <= 32'd0;
      active_blank <= 8'hFF;
    end else if (commit) begin
      active_data  <= pend_data;
      active_blank <= pend_blank;
    end
  end

  // Output muxes take only registered state, so they change only on clock edges.
  always_comb begin
    num        = active_data[{sel, 2'b00} +: 4];
    digit_en   = ~active_blank[sel];
    load_ready = ~pending;
  end

endmodule
